// File: rtl/vga_cap_pkg.sv
// Shared types, defaults and the pixel packing function for the VGA frame capture writer.
package vga_cap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_e;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int ADDR_W       = 19;

    // Palette index layout must match the palette ROM: {R[7:5], G[7:5], B[7:6]}
    function automatic logic [7:0] rgb332(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b);
        return {r[7:5], g[7:5], b[7:6]};
    endfunction

endpackage

// File: rtl/vga_in_stage.sv
// Stage-1 input registers for the VGA stream plus the inactive->active VS frame-edge detector.
module vga_in_stage #(
    parameter bit VS_ACT_LOW = 1'b1
) (
    input  logic       iVGA_CLK,
    input  logic       iRST_n,
    input  logic       hs_i,
    input  logic       vs_i,
    input  logic       blank_n_i,
    input  logic [7:0] r_i,
    input  logic [7:0] g_i,
    input  logic [7:0] b_i,
    output logic       hs_o,
    output logic       blank_n_o,
    output logic [7:0] r_o,
    output logic [7:0] g_o,
    output logic [7:0] b_o,
    output logic       frame_edge_o
);

    // Reset VS to its inactive level so leaving reset never looks like a frame edge
    localparam logic VS_IDLE = VS_ACT_LOW ? 1'b1 : 1'b0;

    logic       hs_q;
    logic       vs_q;
    logic       vs_prev_q;
    logic       blank_n_q;
    logic [7:0] r_q;
    logic [7:0] g_q;
    logic [7:0] b_q;
    logic       vs_act_s;
    logic       vs_prev_act_s;

    // Stage-1 sample of the incoming stream and the previous stage-1 VS
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            hs_q      <= 1'b0;
            vs_q      <= VS_IDLE;
            vs_prev_q <= VS_IDLE;
            blank_n_q <= 1'b0;
            r_q       <= 8'd0;
            g_q       <= 8'd0;
            b_q       <= 8'd0;
        end else begin
            hs_q      <= hs_i;
            vs_q      <= vs_i;
            vs_prev_q <= vs_q;
            blank_n_q <= blank_n_i;
            r_q       <= r_i;
            g_q       <= g_i;
            b_q       <= b_i;
        end
    end

    assign vs_act_s      = vs_q ^ VS_ACT_LOW;
    assign vs_prev_act_s = vs_prev_q ^ VS_ACT_LOW;
    assign frame_edge_o  = vs_act_s & ~vs_prev_act_s;

    assign hs_o      = hs_q;
    assign blank_n_o = blank_n_q;
    assign r_o       = r_q;
    assign g_o       = g_q;
    assign b_o       = b_q;

endmodule

// File: rtl/vga_frame_capture.sv
// Writer side of the VGA framebuffer: captures active pixels as RGB332 into the frame RAM
// under a start/stop handshake, single-shot or continuous.
module vga_frame_capture
    import vga_cap_pkg::*;
#(
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int FRAME_PIXELS = H_ACTIVE * V_ACTIVE,
    parameter bit VS_ACT_LOW   = 1'b1
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        iSTART,
    input  logic        iCONT,
    input  logic        iSTOP,
    input  logic        iHS,
    input  logic        iVS,
    input  logic        iBLANK_n,
    input  logic [7:0]  iR,
    input  logic [7:0]  iG,
    input  logic [7:0]  iB,
    output logic        owren,
    output logic [18:0] oaddr,
    output logic [7:0]  odata,
    output logic        oBUSY,
    output logic        oDONE,
    output logic [7:0]  oFRAME_CNT,
    output logic        oOVF,
    output logic        oSHORT
);

    // One spare bit so the counter can reach FRAME_PIXELS and flag overflow without wrapping
    localparam int                 CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]   FP_L  = CNT_W'(FRAME_PIXELS);
    localparam logic [CNT_W-1:0]   ONE_L = CNT_W'(1);

    cap_state_e         state_q, state_d;
    logic               cont_q, cont_d;
    logic [CNT_W-1:0]   addr_q, addr_d;
    logic               owren_q, owren_d;
    logic [ADDR_W-1:0]  oaddr_q, oaddr_d;
    logic [7:0]         odata_q, odata_d;
    logic               done_q, done_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               short_q, short_d;
    logic               busy_q, busy_d;

    logic               hs_s;
    logic               blank_s;
    logic [7:0]         r_s, g_s, b_s;
    logic               frame_edge_s;
    logic               room_s;
    logic               unused_hs_s;

    vga_in_stage #(
        .VS_ACT_LOW (VS_ACT_LOW)
    ) u_in_stage (
        .iVGA_CLK     (iVGA_CLK),
        .iRST_n       (iRST_n),
        .hs_i         (iHS),
        .vs_i         (iVS),
        .blank_n_i    (iBLANK_n),
        .r_i          (iR),
        .g_i          (iG),
        .b_i          (iB),
        .hs_o         (hs_s),
        .blank_n_o    (blank_s),
        .r_o          (r_s),
        .g_o          (g_s),
        .b_o          (b_s),
        .frame_edge_o (frame_edge_s)
    );

    assign unused_hs_s = hs_s;
    assign room_s      = (addr_q < FP_L);

    // FSM state register
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an edge seen while still IDLE/DONE is not consumed by the arming start
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (iSTART) state_d = ARM;
                else        state_d = state_q;
            end
            ARM: begin
                if (frame_edge_s) state_d = CAPTURE;
                else              state_d = ARM;
            end
            CAPTURE: begin
                if (frame_edge_s) state_d = (cont_q & ~iSTOP) ? CAPTURE : DONE;
                else              state_d = CAPTURE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values; the frame edge wins over a coincident active pixel
    always_comb begin
        cont_d  = cont_q;
        addr_d  = addr_q;
        owren_d = 1'b0;
        oaddr_d = oaddr_q;
        odata_d = odata_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        short_d = short_q;
        case (state_q)
            IDLE, DONE: begin
                if (iSTART) begin
                    cont_d  = iCONT & ~iSTOP;
                    cnt_d   = 8'd0;
                    ovf_d   = 1'b0;
                    short_d = 1'b0;
                end else begin
                    cont_d  = cont_q;
                end
            end
            ARM: begin
                cont_d = cont_q & ~iSTOP;
                if (frame_edge_s) addr_d = {CNT_W{1'b0}};
                else              addr_d = addr_q;
            end
            CAPTURE: begin
                cont_d = cont_q & ~iSTOP;
                if (frame_edge_s) begin
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    short_d = short_q | room_s;
                    addr_d  = {CNT_W{1'b0}};
                end else if (blank_s) begin
                    if (room_s) begin
                        owren_d = 1'b1;
                        oaddr_d = addr_q[ADDR_W-1:0];
                        odata_d = rgb332(r_s, g_s, b_s);
                        addr_d  = addr_q + ONE_L;
                    end else begin
                        ovf_d   = 1'b1;
                    end
                end else begin
                    addr_d = addr_q;
                end
            end
            default: begin
                cont_d = 1'b0;
            end
        endcase
        busy_d = (state_d == ARM) || (state_d == CAPTURE);
    end

    // Stage-2 write port, address counter and status registers
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            cont_q  <= 1'b0;
            addr_q  <= {CNT_W{1'b0}};
            owren_q <= 1'b0;
            oaddr_q <= {ADDR_W{1'b0}};
            odata_q <= 8'd0;
            done_q  <= 1'b0;
            cnt_q   <= 8'd0;
            ovf_q   <= 1'b0;
            short_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            cont_q  <= cont_d;
            addr_q  <= addr_d;
            owren_q <= owren_d;
            oaddr_q <= oaddr_d;
            odata_q <= odata_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            short_q <= short_d;
            busy_q  <= busy_d;
        end
    end

    assign owren      = owren_q;
    assign oaddr      = oaddr_q;
    assign odata      = odata_q;
    assign oBUSY      = busy_q;
    assign oDONE      = done_q;
    assign oFRAME_CNT = cnt_q;
    assign oOVF       = ovf_q;
    assign oSHORT     = short_q;

endmodule
